lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Memory-access stage directly upstream of the integer register file.
- Takes the EX-stage result and either passes ALU results through to register writeback, or performs one load/store on a simple req/ack data bus.
- Drives the register file write port (we/waddr/wdata) from registers.
- Stalls the upstream pipeline while a bus transaction is outstanding.

Parameters:
- None.

Ports:
clk  input  1  clock, all logic on posedge
rst_  input  1  synchronous, active-high reset (rst_==1 at posedge resets)
valid_i  input  1  EX stage presents an instruction this cycle
mem_op_i  input  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
size_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
unsigned_i  input  1  load zero-extends when 1, sign-extends when 0
addr_i  input  32  ALU result / effective address
sdata_i  input  32  store data (rs2 value)
rd_we_i  input  1  instruction writes rd
rd_i  input  5  destination register index
stall_o  output  1  upstream must hold its current instruction
bus_req_o  output  1  bus request, held until ack
bus_we_o  output  1  1 = store, 0 = load
bus_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
bus_wdata_o  output  32  lane-replicated store data
bus_be_o  output  4  byte enables
bus_ack_i  input  1  bus completes transaction this cycle
bus_rdata_i  input  32  load data, valid when bus_ack_i==1
we_o  output  1  register file write enable
waddr_o  output  5  register file write index
wdata_o  output  32  register file write data
exc_o  output  1  misaligned-access exception pulse (see Optional Feature)

Behaviour:
- Reset: state IDLE. All outputs are 0: bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, we_o, waddr_o, wdata_o, exc_o, stall_o. Reset mid-transaction abandons it; bus_req_o is low in the cycle after the reset edge.
- FSM states: IDLE, BUS.
- stall_o = (state==BUS), combinational.
- IDLE, valid_i, mem_op none/reserved:
  - Registered at edge E0: we_o=rd_we_i && rd_i!=0, waddr_o=rd_i, wdata_o=addr_i.
  - Latency 1 cycle. we_o is a single-cycle pulse and is cleared on every edge that has no new write.
- IDLE, valid_i, load/store: capture at E0, then go to BUS.
  - bus_req_o, bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are registered and stable for the whole BUS state.
  - Latched size, unsigned_i, addr[1:0], rd_we_i and rd_i are held internally.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- Store data:
  - byte: {4{sdata[7:0]}}.
  - half: {2{sdata[15:0]}}.
  - word: sdata.
- BUS, bus_ack_i==0: hold everything.
- BUS, bus_ack_i==1 sampled at edge Ek: go to IDLE and drop bus_req_o.
  - Load: at Ek register we_o=rd_we && rd!=0, waddr_o=rd, wdata_o=selected lane, sign- or zero-extended per latched unsigned_i.
  - Store: no writeback.
- Minimum load latency: accept at E0, ack at E1, we_o high after E1.
- While in BUS, valid_i and all EX inputs are ignored. Upstream holds them, and they are accepted in the first IDLE cycle.
- bus_ack_i while IDLE is ignored.
- Back-to-back memory ops: the next op is accepted at the edge after the ack edge. bus_req_o is therefore low for at least one cycle between transactions.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half-word with addr[0]==1 or a word with addr[1:0]!=0 is misaligned.
  - No bus request is issued, no writeback is performed, and state stays IDLE.
  - exc_o is a one-cycle pulse registered at the acceptance edge.
- Undefined: exc_o is tied to 0.
  - Half-words select their lane by addr[1] only.
  - Words ignore addr[1:0].
  - The access proceeds normally.

Test Plan:
- Non-memory op: addr_i=0x12345678, rd_i=5, rd_we_i=1 -> one cycle later we_o=1, waddr_o=5, wdata_o=0x12345678. Repeat with rd_i=0 -> we_o stays 0.
- Signed byte load: addr_i=0x1003, ack on the first BUS cycle, bus_rdata_i=0x80FFFFFF -> bus_addr_o=0x1000, bus_be_o=1000, wdata_o=0xFFFFFF80. Same with unsigned_i=1 -> 0x00000080.
- Half store: addr_i=0x2002, sdata_i=0xAAAABEEF, ack delayed 3 cycles -> bus_be_o=1100, bus_wdata_o=0xBEEFBEEF, stall_o high for 4 cycles, no we_o.
- Reset mid-transaction: rst_=1 while in BUS with no ack -> next cycle bus_req_o=0, stall_o=0, we_o=0. A subsequent load completes normally.
- Back-to-back: word load then word store, each acked immediately -> bus_req_o shows a gap of at least 1 cycle between them, and the load writeback precedes the store request.
- With MISALIGN_TRAP_EN: word load at addr 0x3001 -> exc_o pulses 1 cycle, bus_req_o stays 0, we_o stays 0.

Source files
------------

// File: rtl/lsu_stage.sv
// Memory-access stage: passes ALU results to the register file, or runs one load/store on a req/ack bus.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses raise exc_o instead of going to the bus.
module lsu_stage (
  input  logic        clk,
  input  logic        rst_,
  input  logic        valid_i,
  input  logic [1:0]  mem_op_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        exc_o
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  state_t      state, state_nxt;
  logic        bus_req_nxt, bus_we_nxt, we_nxt, exc_nxt, accept_mem;
  logic [31:0] bus_addr_nxt, bus_wdata_nxt, wdata_nxt;
  logic [3:0]  bus_be_nxt;
  logic [4:0]  waddr_nxt;
  logic        is_mem, misaligned;

  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [1:0]  off_p0;
  logic        rd_we_p0;
  logic [4:0]  rd_p0;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] sdata);
    case (size)
      SZ_BYTE: store_lanes = {4{sdata[7:0]}};
      SZ_HALF: store_lanes = {2{sdata[15:0]}};
      default: store_lanes = sdata;
    endcase
  endfunction

  // Selects the addressed lane of the read word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = rdata;
    endcase
  endfunction

  assign is_mem  = (mem_op_i == OP_LOAD) || (mem_op_i == OP_STORE);
  assign stall_o = (state == BUS);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size_i == SZ_HALF) && addr_i[0]) ||
                      ((size_i[1] == 1'b1) && (addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    bus_req_nxt   = bus_req_o;
    bus_we_nxt    = bus_we_o;
    bus_addr_nxt  = bus_addr_o;
    bus_wdata_nxt = bus_wdata_o;
    bus_be_nxt    = bus_be_o;
    we_nxt        = 1'b0;
    waddr_nxt     = waddr_o;
    wdata_nxt     = wdata_o;
    exc_nxt       = 1'b0;
    accept_mem    = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) begin
          if (is_mem) begin
            if (misaligned) begin
              exc_nxt = 1'b1;
            end else begin
              accept_mem    = 1'b1;
              state_nxt     = BUS;
              bus_req_nxt   = 1'b1;
              bus_we_nxt    = (mem_op_i == OP_STORE);
              bus_addr_nxt  = {addr_i[31:2], 2'b00};
              bus_be_nxt    = byte_en(size_i, addr_i[1:0]);
              bus_wdata_nxt = store_lanes(size_i, sdata_i);
            end
          end else begin
            we_nxt    = rd_we_i && (rd_i != 5'd0);
            waddr_nxt = rd_i;
            wdata_nxt = addr_i;
          end
        end
      end
      BUS: begin
        // EX inputs are ignored here; upstream holds them until stall_o drops.
        if (bus_ack_i) begin
          state_nxt   = IDLE;
          bus_req_nxt = 1'b0;
          if (!bus_we_o) begin
            we_nxt    = rd_we_p0 && (rd_p0 != 5'd0);
            waddr_nxt = rd_p0;
            wdata_nxt = load_extend(size_p0, uns_p0, off_p0, bus_rdata_i);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_wdata_o <= 32'd0;
      bus_be_o    <= 4'd0;
      we_o        <= 1'b0;
      waddr_o     <= 5'd0;
      wdata_o     <= 32'd0;
      exc_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus_req_o   <= bus_req_nxt;
      bus_we_o    <= bus_we_nxt;
      bus_addr_o  <= bus_addr_nxt;
      bus_wdata_o <= bus_wdata_nxt;
      bus_be_o    <= bus_be_nxt;
      we_o        <= we_nxt;
      waddr_o     <= waddr_nxt;
      wdata_o     <= wdata_nxt;
      exc_o       <= exc_nxt;
    end
  end

  // Access attributes needed at ack time, captured at acceptance.
  always_ff @(posedge clk) begin
    if (accept_mem) begin
      size_p0  <= size_i;
      uns_p0   <= unsigned_i;
      off_p0   <= addr_i[1:0];
      rd_we_p0 <= rd_we_i;
      rd_p0    <= rd_i;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: vector table plus hand sequences; writebacks checked against a queue of expected results.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_;
  logic        valid_i;
  logic [1:0]  mem_op_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] sdata_i;
  logic        rd_we_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        exc_o;

  lsu_stage dut (
    .clk(clk), .rst_(rst_), .valid_i(valid_i), .mem_op_i(mem_op_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .sdata_i(sdata_i), .rd_we_i(rd_we_i), .rd_i(rd_i),
    .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .exc_o(exc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic        wb;
    logic [31:0] wbdata;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];
  wb_t  sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] sdata, input logic rd_we,
                              input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                              input logic [3:0] be, input logic [31:0] bwdata, input logic wb,
                              input logic [31:0] wbdata);
    vec_t v;
    v.op = op; v.size = size; v.uns = uns; v.addr = addr; v.sdata = sdata; v.rd_we = rd_we;
    v.rd = rd; v.rdata = rdata; v.delay = delay; v.be = be; v.bwdata = bwdata; v.wb = wb;
    v.wbdata = wbdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and retire any writeback against the expected-result queue.
  task automatic tick();
    @(posedge clk);
    #1;
    if (we_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got waddr %0d wdata %h expected no write", waddr_o, wdata_o);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_addr", {27'd0, waddr_o}, {27'd0, e.rd});
        chk("wb_data", wdata_o, e.data);
      end
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic rd_we,
                       input logic [4:0] rd);
    valid_i = 1'b1; mem_op_i = op; size_i = size; unsigned_i = uns;
    addr_i = addr; sdata_i = sdata; rd_we_i = rd_we; rd_i = rd;
  endtask

  task automatic run_vec(input vec_t v);
    bit is_mem;
    int stalls;
    is_mem = (v.op == 2'b01) || (v.op == 2'b10);
    drive(v.op, v.size, v.uns, v.addr, v.sdata, v.rd_we, v.rd);
    bus_ack_i = 1'b0;
    if (v.wb) sb.push_back('{v.rd, v.wbdata});
    tick();
    if (!is_mem) begin
      valid_i = 1'b0;
      chk("alu_stall", {31'd0, stall_o}, 32'd0);
      chk("alu_req", {31'd0, bus_req_o}, 32'd0);
    end else begin
      chk("req", {31'd0, bus_req_o}, 32'd1);
      chk("bus_we", {31'd0, bus_we_o}, {31'd0, v.op == 2'b10});
      chk("bus_addr", bus_addr_o, {v.addr[31:2], 2'b00});
      chk("bus_be", {28'd0, bus_be_o}, {28'd0, v.be});
      if (v.op == 2'b10) chk("bus_wdata", bus_wdata_o, v.bwdata);
      stalls = 0;
      for (int i = 0; i <= v.delay; i++) begin
        if (stall_o) stalls++;
        if (i == v.delay) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = v.rdata;
        end
        tick();
        if (i < v.delay) chk("bus_hold", {31'd0, bus_req_o}, 32'd1);
      end
      bus_ack_i = 1'b0;
      valid_i   = 1'b0;
      chk("stall_cycles", stalls, v.delay + 1);
      chk("req_drop", {31'd0, bus_req_o}, 32'd0);
      chk("stall_drop", {31'd0, stall_o}, 32'd0);
    end
    chk("wb_pending", sb.size(), 32'd0);
    tick();
  endtask

  initial begin
    vecs[0]  = mk(2'b00, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 5'd5,  32'h0, 0, 4'h0, 32'h0, 1'b1, 32'h1234_5678);
    vecs[1]  = mk(2'b00, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 5'd0,  32'h0, 0, 4'h0, 32'h0, 1'b0, 32'h0);
    vecs[2]  = mk(2'b01, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 1'b1, 5'd7,  32'h80FF_FFFF, 0, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80);
    vecs[3]  = mk(2'b01, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 1'b1, 5'd7,  32'h80FF_FFFF, 0, 4'b1000, 32'h0, 1'b1, 32'h0000_0080);
    vecs[4]  = mk(2'b10, 2'b01, 1'b0, 32'h0000_2002, 32'hAAAA_BEEF, 1'b0, 5'd0, 32'h0, 3, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0);
    vecs[5]  = mk(2'b01, 2'b01, 1'b0, 32'h0000_2000, 32'h0, 1'b1, 5'd8,  32'h1234_8001, 0, 4'b0011, 32'h0, 1'b1, 32'hFFFF_8001);
    vecs[6]  = mk(2'b01, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 1'b1, 5'd9,  32'h8001_0000, 2, 4'b1100, 32'h0, 1'b1, 32'h0000_8001);
    vecs[7]  = mk(2'b01, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 5'd31, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF);
    vecs[8]  = mk(2'b10, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00A5, 1'b1, 5'd2, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0);
    vecs[9]  = mk(2'b01, 2'b00, 1'b1, 32'h0000_6001, 32'h0, 1'b1, 5'd11, 32'h0000_7F00, 1, 4'b0010, 32'h0, 1'b1, 32'h0000_007F);
    vecs[10] = mk(2'b01, 2'b00, 1'b0, 32'h0000_6002, 32'h0, 1'b0, 5'd12, 32'h00AB_0000, 0, 4'b0100, 32'h0, 1'b0, 32'h0);
    vecs[11] = mk(2'b10, 2'b10, 1'b0, 32'h0000_7004, 32'h1122_3344, 1'b0, 5'd0, 32'h0, 2, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);
    vecs[12] = mk(2'b11, 2'b00, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b1, 5'd3,  32'h0, 0, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D);
    vecs[13] = mk(2'b01, 2'b11, 1'b0, 32'h0000_7008, 32'h0, 1'b1, 5'd12, 32'h0F0F_0F0F, 0, 4'b1111, 32'h0, 1'b1, 32'h0F0F_0F0F);
    vecs[14] = mk(2'b01, 2'b00, 1'b0, 32'h0000_6000, 32'h0, 1'b1, 5'd1,  32'h0000_007F, 0, 4'b0001, 32'h0, 1'b1, 32'h0000_007F);

    rst_ = 1'b1; valid_i = 1'b0; mem_op_i = 2'b00; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h0; sdata_i = 32'h0; rd_we_i = 1'b0; rd_i = 5'd0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    tick();
    tick();
    chk("rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we_o}, 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_bus_wdata", bus_wdata_o, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be_o}, 32'd0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_waddr", {27'd0, waddr_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_exc", {31'd0, exc_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    rst_ = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Ack while idle must do nothing.
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0;
    chk("idle_ack_stall", {31'd0, stall_o}, 32'd0);
    chk("idle_ack_req", {31'd0, bus_req_o}, 32'd0);

    // Reset in the middle of an un-acked load abandons it.
    drive(2'b01, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 1'b1, 5'd9);
    tick();
    valid_i = 1'b0;
    chk("mid_req", {31'd0, bus_req_o}, 32'd1);
    tick();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    chk("mid_rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("mid_rst_we", {31'd0, we_o}, 32'd0);
    tick();
    run_vec(mk(2'b01, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 1'b1, 5'd9, 32'h0BAD_F00D, 1, 4'b1111, 32'h0, 1'b1, 32'h0BAD_F00D));

    // Back-to-back load then store: writeback lands before the store request, with a req gap.
    sb.push_back('{5'd10, 32'h5566_7788});
    drive(2'b01, 2'b10, 1'b0, 32'h0000_9000, 32'h0, 1'b1, 5'd10);
    tick();
    chk("b2b_load_req", {31'd0, bus_req_o}, 32'd1);
    drive(2'b10, 2'b10, 1'b0, 32'h0000_A000, 32'h0102_0304, 1'b0, 5'd0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5566_7788;
    tick();
    bus_ack_i = 1'b0;
    chk("b2b_gap_req", {31'd0, bus_req_o}, 32'd0);
    chk("b2b_load_we", {31'd0, we_o}, 32'd1);
    chk("b2b_gap_stall", {31'd0, stall_o}, 32'd0);
    tick();
    valid_i = 1'b0;
    chk("b2b_store_req", {31'd0, bus_req_o}, 32'd1);
    chk("b2b_store_we", {31'd0, bus_we_o}, 32'd1);
    chk("b2b_store_addr", bus_addr_o, 32'h0000_A000);
    chk("b2b_store_data", bus_wdata_o, 32'h0102_0304);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    chk("b2b_store_done", {31'd0, bus_req_o}, 32'd0);
    chk("b2b_pending", sb.size(), 32'd0);
    tick();

`ifdef MISALIGN_TRAP_EN
    drive(2'b01, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 1'b1, 5'd4);
    tick();
    valid_i = 1'b0;
    chk("mis_exc", {31'd0, exc_o}, 32'd1);
    chk("mis_req", {31'd0, bus_req_o}, 32'd0);
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("mis_exc_pulse", {31'd0, exc_o}, 32'd0);
    chk("mis_req_after", {31'd0, bus_req_o}, 32'd0);
`else
    run_vec(mk(2'b01, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 1'b1, 5'd4, 32'hA1B2_C3D4, 0, 4'b1111, 32'h0, 1'b1, 32'hA1B2_C3D4));
    chk("mis_exc_off", {31'd0, exc_o}, 32'd0);
    run_vec(mk(2'b01, 2'b01, 1'b1, 32'h0000_2003, 32'h0, 1'b1, 5'd6, 32'hC0DE_0000, 0, 4'b1100, 32'h0, 1'b1, 32'h0000_C0DE));
`endif

    chk("final_pending", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
